// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter states and the frame-format encodings
// used by the transmitter, receiver and configuration registers.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam logic [1:0] DW5 = 2'b00;
    localparam logic [1:0] DW6 = 2'b01;
    localparam logic [1:0] DW7 = 2'b10;
    localparam logic [1:0] DW8 = 2'b11;

    localparam logic [1:0] PAR_EVEN = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_NONE = 2'b10;

    localparam logic [1:0] STOP_1 = 2'b00;
    localparam logic [1:0] STOP_2 = 2'b01;

    function automatic logic [3:0] data_bits(input logic [1:0] width_code);
        return {2'b00, width_code} + 4'd5;
    endfunction

endpackage

// File: rtl/uart_transmitter.sv
// UART transmit serialiser: pops bytes from the TX FIFO and shifts out
// start, data, optional parity and stop bits, timed by the baud tick.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       baud_tick_i,
    input  logic       tx_enable_i,
    input  logic [1:0] data_width_i,
    input  logic [1:0] parity_mode_i,
    input  logic [1:0] stop_bits_i,
    input  logic       tx_dsm_i,
    input  logic       fifo_empty_i,
    input  logic [7:0] fifo_data_i,
    output logic       fifo_read_o,
    output logic       tx_o,
    output logic       tx_idle_o,
    output logic       tx_done_o
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);

    tx_state_t   state, state_next;
    logic [CW-1:0] tick_cnt;
    logic [2:0]  bit_cnt;
    logic        stop_cnt;
    logic [7:0]  shift_reg;
    logic [1:0]  width_q;
    logic        parity_en_q;
    logic        two_stop_q;
    logic        dsm_q;
    logic        parity_bit;

    logic        bit_end;
    logic        last_data_bit;
    logic        last_stop_bit;
    logic        pop_ok;
    logic        frame_parity;

    assign bit_end       = baud_tick_i && (tick_cnt == CW'(OVERSAMPLE - 1));
    assign last_data_bit = ({1'b0, bit_cnt} == (data_bits(width_q) - 4'd1));
    assign last_stop_bit = !two_stop_q || stop_cnt;
    assign pop_ok        = tx_enable_i && !fifo_empty_i;

    // Odd parity seeds the XOR with 1; bits above the selected width are masked.
    always_comb begin
        frame_parity = parity_mode_i[0];
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < 32'(data_bits(data_width_i))) begin
                frame_parity = frame_parity ^ fifo_data_i[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (pop_ok) state_next = ST_LOAD;
            ST_LOAD:   state_next = ST_START;
            ST_START:  if (bit_end) state_next = ST_DATA;
            ST_DATA:   if (bit_end && last_data_bit)
                           state_next = parity_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_next = ST_STOP;
            ST_STOP:   if (bit_end && last_stop_bit)
                           state_next = (dsm_q && pop_ok) ? ST_LOAD : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_o        = 1'b1;
        tx_idle_o   = 1'b0;
        fifo_read_o = 1'b0;
        tx_done_o   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                tx_idle_o   = 1'b1;
                fifo_read_o = pop_ok && !rst_i;
            end
            ST_START:  tx_o = 1'b0;
            ST_DATA:   tx_o = shift_reg[0];
            ST_PARITY: tx_o = parity_bit;
            ST_STOP: begin
                if (bit_end && last_stop_bit && !rst_i) begin
                    fifo_read_o = dsm_q && pop_ok;
                    tx_done_o   = !(dsm_q && pop_ok);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            stop_cnt    <= 1'b0;
            shift_reg   <= '0;
            width_q     <= '0;
            parity_en_q <= 1'b0;
            two_stop_q  <= 1'b0;
            dsm_q       <= 1'b0;
            parity_bit  <= 1'b0;
        end else begin
            if (state == ST_LOAD) begin
                shift_reg   <= fifo_data_i;
                width_q     <= data_width_i;
                parity_en_q <= !parity_mode_i[1];
                two_stop_q  <= (stop_bits_i == STOP_2);
                dsm_q       <= tx_dsm_i;
                parity_bit  <= frame_parity;
                tick_cnt    <= '0;
                bit_cnt     <= '0;
                stop_cnt    <= 1'b0;
            end else if (state != ST_IDLE && baud_tick_i) begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            if (state == ST_DATA && bit_end) begin
                shift_reg <= {1'b0, shift_reg[7:1]};
                bit_cnt   <= bit_cnt + 1'b1;
            end
            if (state == ST_STOP && bit_end) begin
                stop_cnt <= ~stop_cnt;
            end
        end
    end

endmodule
